// File: rtl/cis_line_buf.sv
// CIS line buffer: packs ADC sample pairs into 32-bit words, one line per ping-pong bank, line_int per line.
// rd_data 1 cycle after rd_en; no backpressure (lines into a full bank are dropped, ovf). Option: LINE_BUF_CKSUM_EN.
module cis_line_buf #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sof,
  input  logic              cis_wren,
  input  logic [7:0]        ad1_data,
  input  logic [7:0]        ad2_data,
  input  logic [ADDR_W+1:0] line_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              rd_release,
  output logic              line_int,
  output logic [ADDR_W:0]   line_words,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [31:0]       line_sum
);

  localparam logic [ADDR_W+1:0] MAX_LEN = {1'b1, {(ADDR_W+1){1'b0}}};
  localparam logic [ADDR_W+1:0] ONE     = {{(ADDR_W+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_WAIT, S_FILL, S_DROP} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [2**(ADDR_W+1)];
  logic [ADDR_W+1:0] len_q, cnt, cnt_inc, sof_len;
  logic [15:0]       lo_half, pair;
  logic              wr_bank, wr_bank_nxt, rd_bank;
  logic [1:0]        full, full_nxt;
  logic [ADDR_W:0]   words [2];
  logic              take, complete, start, ovf_set, release_ok;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   mem_waddr;

  assign pair       = {ad2_data, ad1_data};
  assign cnt_inc    = cnt + ONE;
  assign sof_len    = (line_len > MAX_LEN) ? MAX_LEN : line_len;
  assign release_ok = rd_release && full[rd_bank];

  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    complete    = 1'b0;
    start       = 1'b0;
    ovf_set     = 1'b0;
    wr_bank_nxt = wr_bank;
    full_nxt    = full;
    if (state == S_FILL && cis_wren) begin
      take     = 1'b1;
      complete = (cnt_inc == len_q);
    end
    if (release_ok) full_nxt[rd_bank] = 1'b0;
    if (complete) begin
      full_nxt[wr_bank] = 1'b1;
      wr_bank_nxt       = ~wr_bank;
      state_nxt         = S_WAIT;
    end
    // sof sees the post-completion/post-release banks; in DROP it may start the next line directly
    if (sof) begin
      if (state == S_FILL && !complete) ovf_set = 1'b1;
      if (sof_len == '0) begin
        state_nxt = S_WAIT;
      end else if (full_nxt[wr_bank_nxt]) begin
        state_nxt = S_DROP;
        ovf_set   = 1'b1;
      end else begin
        state_nxt = S_FILL;
        start     = 1'b1;
      end
    end
  end

  assign mem_we    = take && (cnt[0] || complete);
  assign mem_wdata = cnt[0] ? {pair, lo_half} : {16'h0000, pair};
  assign mem_waddr = {wr_bank, cnt[ADDR_W:1]};

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= '0;
      cnt      <= '0;
      lo_half  <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= '0;
      words[0] <= '0;
      words[1] <= '0;
      line_int <= 1'b0;
      ovf      <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_bank  <= wr_bank_nxt;
      full     <= full_nxt;
      line_int <= complete;
      if (release_ok) rd_bank <= ~rd_bank;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (start) begin
        len_q <= sof_len;
        cnt   <= '0;
      end else if (take) begin
        cnt <= cnt_inc;
      end
      if (take && !cnt[0]) lo_half <= pair;
      if (complete) words[wr_bank] <= len_q[ADDR_W+1:1] + {{ADDR_W{1'b0}}, len_q[0]};
      if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

  assign line_words = words[rd_bank];

`ifdef LINE_BUF_CKSUM_EN
  logic [31:0] acc, acc_nxt;
  logic [31:0] sums [2];

  assign acc_nxt = acc + {24'h0, ad1_data} + {24'h0, ad2_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      sums[0] <= '0;
      sums[1] <= '0;
    end else begin
      if (start)     acc <= '0;
      else if (take) acc <= acc_nxt;
      if (complete) sums[wr_bank] <= acc_nxt;
    end
  end

  assign line_sum = sums[rd_bank];
`else
  assign line_sum = 32'h0;
`endif

endmodule

// File: tb/tb_cis_line_buf.sv
// Bench for cis_line_buf: transaction-level model predicts line_int cycles, read words and status;
// a monitor process checks pulses and read data against the expected queues.
module tb_cis_line_buf;
  localparam int AW   = 10;
  localparam int MAXP = 2**(AW+1);

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          sof = 1'b0, cis_wren = 1'b0, rd_en = 1'b0, rd_release = 1'b0, ovf_clr = 1'b0;
  logic [7:0]    ad1_data = 8'h0, ad2_data = 8'h0;
  logic [AW+1:0] line_len = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data, line_sum;
  logic          line_int, ovf;
  logic [AW:0]   line_words;

  cis_line_buf #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .sof(sof), .cis_wren(cis_wren),
    .ad1_data(ad1_data), .ad2_data(ad2_data), .line_len(line_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_release(rd_release),
    .line_int(line_int), .line_words(line_words), .ovf(ovf), .ovf_clr(ovf_clr),
    .line_sum(line_sum)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          exp_int_q[$];
  logic [31:0] exp_rd_q[$];

  // reference model: bank contents and bookkeeping per line, not per cycle
  logic [31:0] m_mem [2][MAXP/2];
  bit          m_full [2];
  int          m_words [2];
  logic [31:0] m_sum [2];
  bit          m_wr, m_rd, m_ovf;
  int          m_mode;  // 0 idle, 1 capturing, 2 dropping
  int          m_len;
  logic [15:0] pq[$];

  always @(posedge clk) begin
    bit rd_seen;
    rd_seen = rd_en;
    #1;
    if (line_int) begin
      n_vec++;
      if (exp_int_q.size() == 0) begin
        n_err++;
        $display("FAIL line_int: unexpected pulse at cycle %0d, none required", cyc);
      end else begin
        int e;
        e = exp_int_q.pop_front();
        if (e != cyc) begin
          n_err++;
          $display("FAIL line_int: pulse at cycle %0d, required at %0d", cyc, e);
        end
      end
    end else if (exp_int_q.size() > 0 && exp_int_q[0] <= cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL line_int: no pulse at cycle %0d, required at %0d", cyc, exp_int_q[0]);
      void'(exp_int_q.pop_front());
    end
    if (rd_seen) begin
      n_vec++;
      if (exp_rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: got %h, no read expected", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_rd_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data: got %h, required %h", rd_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_full  = '{0, 0};
    m_words = '{0, 0};
    m_sum   = '{32'h0, 32'h0};
    m_wr = 0; m_rd = 0; m_ovf = 0; m_mode = 0; m_len = 0;
  endfunction

  function automatic int clamp(input int len);
    return (len > MAXP) ? MAXP : len;
  endfunction

  function automatic void m_release();
    if (m_full[m_rd]) begin
      m_full[m_rd] = 0;
      m_rd = !m_rd;
    end
  endfunction

  function automatic void m_sof(input int len, input bit clr);
    if (clr) m_ovf = 0;
    if (m_mode == 1) m_ovf = 1;
    if (clamp(len) == 0) m_mode = 0;
    else if (m_full[m_wr]) begin m_mode = 2; m_ovf = 1; end
    else begin m_mode = 1; m_len = clamp(len); end
  endfunction

  task automatic step(input bit s, input int len, input bit w, input logic [15:0] p,
                      input bit rel, input bit rde, input int ra, input bit clr);
    @(negedge clk);
    sof = s; line_len = len[AW+1:0]; cis_wren = w;
    ad1_data = p[7:0]; ad2_data = p[15:8];
    rd_release = rel; rd_en = rde; rd_addr = ra[AW-1:0]; ovf_clr = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic check_status(input string tag);
    idle(1);
    check({tag, " line_words"}, 32'(line_words), m_words[m_rd]);
    check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
`ifdef LINE_BUF_CKSUM_EN
    check({tag, " line_sum"}, line_sum, m_sum[m_rd]);
`else
    check({tag, " line_sum"}, line_sum, 32'h0);
`endif
  endtask

  task automatic send_line(input int len, input bit no_sof, input bit rel_last,
                           input int chain_len, input int max_gap, input bit clr);
    int          n, mode;
    logic [31:0] words[$];
    logic [31:0] sum;
    if (!no_sof) begin
      step(1, len, 0, 16'h0, 0, 0, 0, clr);
      m_sof(len, clr);
    end
    mode = m_mode;
    n = (mode == 0) ? 0 : clamp(len);
    while (pq.size() < n) pq.push_back(16'($urandom));
    sum = 0;
    for (int i = 0; i < n; i++) begin
      sum += pq[i][7:0] + pq[i][15:8];
      if (i % 2 == 1) words.push_back({pq[i], pq[i-1]});
      else if (i == n - 1) words.push_back({16'h0000, pq[i]});
    end
    for (int i = 0; i < n; i++) begin
      bit last;
      last = (i == n - 1);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
      step(last && chain_len > 0, chain_len, 1, pq[i], last && rel_last, 0, 0, 0);
      if (last) begin
        if (rel_last) m_release();
        if (mode == 1) begin
          exp_int_q.push_back(cyc + 1);
          for (int k = 0; k < words.size(); k++) m_mem[m_wr][k] = words[k];
          m_words[m_wr] = words.size();
          m_sum[m_wr]   = sum;
          m_full[m_wr]  = 1;
          m_wr   = !m_wr;
          m_mode = 0;
        end
        if (chain_len > 0) m_sof(chain_len, 0);
      end
    end
    pq.delete();
  endtask

  task automatic partial(input int len, input int k);
    step(1, len, 0, 16'h0, 0, 0, 0, 0);
    m_sof(len, 0);
    for (int i = 0; i < k; i++) step(0, 0, 1, 16'($urandom), 0, 0, 0, 0);
  endtask

  task automatic read_all();
    if (m_full[m_rd]) begin
      for (int i = 0; i < m_words[m_rd]; i++) begin
        step(0, 0, 0, 16'h0, 0, 1, i, 0);
        exp_rd_q.push_back(m_mem[m_rd][i]);
      end
    end
    idle(1);
  endtask

  task automatic do_release();
    step(0, 0, 0, 16'h0, 1, 0, 0, 0);
    m_release();
  endtask

  task automatic do_clr();
    step(0, 0, 0, 16'h0, 0, 0, 0, 1);
    m_ovf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sof = 0; cis_wren = 0; rd_en = 0; rd_release = 0; ovf_clr = 0;
    #1;
    check("async reset line_int", 32'(line_int), 0);
    check("async reset ovf", 32'(ovf), 0);
    check("async reset line_words", 32'(line_words), 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    exp_int_q.delete();
    pq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_reset();
    do_reset();
    check("reset rd_data", rd_data, 32'h0);
    check("reset line_int", 32'(line_int), 0);
    check_status("reset");

    pq = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    send_line(4, 0, 0, 0, 0, 0);
    check_status("single");
    check("single line_words", 32'(line_words), 2);
`ifdef LINE_BUF_CKSUM_EN
    check("single line_sum", line_sum, 36);
`endif
    read_all();
    do_release();

    pq = '{16'hBBAA, 16'hBBAA, 16'hBBAA};
    send_line(3, 0, 0, 0, 1, 0);
    check_status("odd");
    check("odd line_words", 32'(line_words), 2);
    read_all();
    do_release();

    send_line($urandom_range(20, 5), 0, 0, 0, 1, 0);
    send_line($urandom_range(20, 5), 0, 0, 0, 1, 0);
    send_line($urandom_range(20, 5), 0, 0, 0, 1, 1);
    check_status("overflow");
    check("overflow ovf", 32'(ovf), 1);
    do_clr();
    check_status("ovf_clr");
    do_release();
    send_line($urandom_range(20, 5), 0, 0, 0, 1, 0);
    check_status("after release");
    read_all();
    do_release();
    read_all();
    do_release();

    partial(8, 2);
    send_line(8, 0, 0, 0, 1, 0);
    check_status("early sof");
    check("early sof line_words", 32'(line_words), 4);
    read_all();
    do_release();
    do_clr();

    send_line(6, 0, 0, 0, 1, 0);
    send_line(10, 0, 1, 0, 1, 0);
    check_status("simultaneous");
    check("simultaneous line_words", 32'(line_words), 5);
    read_all();
    do_release();
    check_status("simultaneous drained");

    send_line(5, 0, 0, 4, 1, 0);
    send_line(4, 1, 0, 0, 1, 0);
    check_status("chained");
    read_all();
    do_release();
    read_all();
    do_release();

    step(1, 0, 0, 16'h0, 0, 0, 0, 0);
    m_sof(0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'($urandom), 0, 0, 0, 0);
    check_status("zero length");

    send_line(4095, 0, 0, 0, 0, 0);
    check_status("clamp");
    check("clamp line_words", 32'(line_words), 1024);
    read_all();
    do_release();

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(5, 0))
        0, 1: send_line($urandom_range(24, 1), 0, 1'($urandom_range(1, 0)), 0,
                        $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        2: read_all();
        3: do_release();
        4: do_clr();
        default: begin
          int l;
          l = $urandom_range(20, 4);
          partial(l, $urandom_range(l - 1, 0));
        end
      endcase
      check_status("random");
    end

    partial(10, 3);
    do_reset();
    check_status("mid-line reset");
    send_line(2, 0, 0, 0, 0, 0);
    check_status("post reset");
    check("post reset line_words", 32'(line_words), 1);
    read_all();
    do_release();

    idle(3);
    check("pending line_int", exp_int_q.size(), 0);
    check("pending reads", exp_rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
